cpu_test_sequencer: RTL
=======================

# cpu_test_sequencer

Synthesizable self-checking test sequencer for `nand_cpu` program regressions. It sits beside the CPU and its main memory. For each test it:
- holds the CPU in reset,
- writes two operands into data memory,
- releases the CPU and waits for `halt`,
- reads back the result word and compares it against a locally computed expected value.

It generalises the single-purpose add-program check to:
- parametrised data width and test count,
- runtime-selectable operation,
- LFSR or externally supplied operands,
- a halt timeout and a first-failure capture.

## Interface
- `DATA_WIDTH`, 16: operand/result width, 1..32
- `ADDR_WIDTH`, 17: memory word-address width
- `DATA_ADDR`, 0: word address of op0; op1 is at +1, result at +2
- `RESET_CYCLES`, 4: cycles `cpu_n_rst` is held low per test, ≥1
- `TIMEOUT_CYCLES`, 65536: cycles to wait for `cpu_halt` before declaring failure
- `CNT_WIDTH`, 16: width of counters and the `num_tests` input
- `clk` in 1: system clock
- `n_rst` in 1: reset, synchronous, active-low
- `start` in 1: pulse; accepted only in IDLE
- `num_tests` in CNT_WIDTH: tests to run; 0 means go straight to DONE
- `op_mode` in 2: 0 ADD, 1 SUB (op0−op1), 2 NAND, 3 AND; latched at start
- `use_ext` in 1: 1 selects `ext_op0`/`ext_op1` for every test, 0 selects the LFSR
- `ext_op0`, `ext_op1` in DATA_WIDTH: external operands, latched at start
- `seed` in 32: LFSR seed, latched at start; 0 is replaced by 1
- `cpu_n_rst` out 1: CPU reset, active-low
- `cpu_halt` in 1: CPU halted
- `mem_req` out 1: memory request
- `mem_we` out 1: 1 write, 0 read
- `mem_addr` out ADDR_WIDTH: word address
- `mem_wdata` out DATA_WIDTH: write data
- `mem_ack` in 1: request accepted; read data valid in the same cycle
- `mem_rdata` in DATA_WIDTH: read data
- `busy` out 1: high in any state except IDLE and DONE
- `done` out 1: high in DONE
- `pass_count`, `fail_count` out CNT_WIDTH: saturating counters
- `timeout_seen` out 1: sticky; set when any test timed out
- `fail_valid` out 1: a failure has been captured
- `fail_index` out CNT_WIDTH: index of the first failing test
- `fail_expected`, `fail_actual` out DATA_WIDTH: values for the first failing test; `fail_actual` is 0 on timeout

## Operation
- FSM states: IDLE, CPU_RST, WR_OP0, WR_OP1, RUN, RD_RES, CHECK, DONE.
- IDLE:
  - On `start`: latch `op_mode`, `use_ext`, `ext_*`, `seed` and `num_tests`.
  - Clear counters and the fail capture, set test index to 0.
  - Go to DONE if `num_tests`==0, else CPU_RST.
- CPU_RST:
  - `cpu_n_rst`=0 for RESET_CYCLES cycles.
  - Operands are selected in this state: the ext values, or LFSR bits [DATA_WIDTH−1:0] and [31:32−DATA_WIDTH].
  - Expected result is computed modulo 2^DATA_WIDTH.
  - Go to WR_OP0.
- WR_OP0 / WR_OP1:
  - Drive `mem_req`=1, `mem_we`=1, address DATA_ADDR / +1.
  - Hold all request signals stable until `mem_ack`, then advance.
  - `cpu_n_rst` stays 0.
- RUN:
  - `cpu_n_rst`=1; the timeout counter starts at 0.
  - `cpu_halt`=1 → RD_RES.
  - Counter reaches TIMEOUT_CYCLES → treat as a fail with actual=0, set `timeout_seen`, go to CHECK's fail path.
- RD_RES:
  - Read request to DATA_ADDR+2; capture `mem_rdata` on `mem_ack`.
  - Go to CHECK.
  - `cpu_n_rst` stays 1 so the CPU remains halted.
- CHECK:
  - Match increments `pass_count`; mismatch increments `fail_count`.
  - The first fail loads the `fail_*` outputs.
  - Step the LFSR once (Fibonacci, taps 32,22,2,1) and increment the index.
  - Go to DONE if index==`num_tests`, else CPU_RST.
- DONE: `cpu_n_rst`=1; hold all results. `start` re-enters as from IDLE.
- `start` outside IDLE/DONE is ignored.
- Counters saturate at all-ones.
- `n_rst` low, including mid-test or mid-handshake, takes effect on the next edge:
  - state goes to IDLE; `mem_req`=0, `cpu_n_rst`=0;
  - counters, `timeout_seen`, `fail_valid` and `fail_*` all cleared to 0.

## Timing
- Reset values:
  - `cpu_n_rst`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `busy`=0, `done`=0, every counter and fail output 0
- `cpu_n_rst` stays 0 in IDLE.
- All outputs are registered.
- `busy` rises the cycle after the `start` edge.
- Per-test overhead with zero-wait memory, excluding the CPU run time: RESET_CYCLES + 2 (writes) + 1 (read) + 1 (CHECK) + 1 (RUN entry).
- `cpu_halt` is ignored while `cpu_n_rst`=0 and in the first RUN cycle.
- `mem_ack` with no request outstanding is ignored.

## Structure
- Package `cpu_test_pkg` holds:
  - the `op_mode_t` enum;
  - the `state_t` enum;
  - the LFSR tap constant;
  - a `compute_expected(op0, op1, mode)` function.
- One sub-module, `lfsr32`: load, step, seed-zero substitution.

## Test plan
- ADD, ext 0x1234/0x0001, 1 test, bench CPU writes 0x1235 → `pass_count`=1, `fail_count`=0, `done`=1.
- SUB, ext 0x0000/0x0001, 1 test, CPU writes 0xFFFF → pass; CPU writes 0x0000 instead → `fail_valid`=1, `fail_index`=0, `fail_expected`=0xFFFF, `fail_actual`=0.
- LFSR mode, seed 0 (substituted), 64 tests, model CPU computes correctly with random memory wait states → `pass_count`=64, and the operands seen by the bench match the reference LFSR sequence.
- CPU never halts, TIMEOUT_CYCLES=100 → each test exits RUN after 100 cycles, `timeout_seen`=1, `fail_count`=`num_tests`.
- `n_rst` asserted while WR_OP1 is waiting for `mem_ack` → next cycle IDLE, `mem_req`=0, `cpu_n_rst`=0, counters 0; a fresh `start` runs normally.
- `num_tests`=0 → DONE in one cycle with no memory traffic; `start` pulses while busy do not restart the run.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// Shared types and helpers for the nand_cpu regression sequencer.
package cpu_test_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_NAND = 2'd2,
    OP_AND  = 2'd3
  } op_mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPU_RST = 3'd1,
    S_WR_OP0  = 3'd2,
    S_WR_OP1  = 3'd3,
    S_RUN     = 3'd4,
    S_RD_RES  = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Fibonacci taps 32,22,2,1 as bit positions 31,21,1,0 of a left-shifting register
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Full 32-bit result; callers keep the low DATA_WIDTH bits, which is the result modulo 2^DATA_WIDTH
  function automatic logic [31:0] compute_expected(input logic [31:0] op0,
                                                   input logic [31:0] op1,
                                                   input op_mode_t    mode);
    case (mode)
      OP_ADD:  return op0 + op1;
      OP_SUB:  return op0 - op1;
      OP_NAND: return ~(op0 & op1);
      default: return op0 & op1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_test_sequencer_lfsr32.sv
// 32-bit Fibonacci LFSR operand source; a zero seed is replaced by 1 so the register never locks up.
module lfsr32
  import cpu_test_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic feedback;

  assign feedback = ^(value & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      value <= 32'h1;
    end else if (load) begin
      value <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      value <= {value[30:0], feedback};
    end
  end

endmodule

// File: rtl/cpu_test_sequencer.sv
// Regression sequencer: resets nand_cpu, writes two operands, waits for halt,
// reads the result back and scores it against a locally computed value.
module cpu_test_sequencer
  import cpu_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned DATA_ADDR      = 0,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_tests,
  input  logic [1:0]            op_mode,
  input  logic                  use_ext,
  input  logic [DATA_WIDTH-1:0] ext_op0,
  input  logic [DATA_WIDTH-1:0] ext_op1,
  input  logic [31:0]           seed,
  output logic                  cpu_n_rst,
  input  logic                  cpu_halt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  timeout_seen,
  output logic                  fail_valid,
  output logic [CNT_WIDTH-1:0]  fail_index,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  op_mode_t              mode_q;
  logic                  use_ext_q;
  logic [DATA_WIDTH-1:0] ext0_q;
  logic [DATA_WIDTH-1:0] ext1_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  idx;
  logic [TMR_W-1:0]      tmr;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [DATA_WIDTH-1:0] act_q;

  logic                  start_ok;
  logic                  lfsr_step;
  logic [31:0]           lfsr_val;
  logic [DATA_WIDTH-1:0] op0_sel;
  logic [DATA_WIDTH-1:0] op1_sel;
  logic [DATA_WIDTH-1:0] exp_sel;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign lfsr_step = (state == S_CHECK);

  lfsr32 u_lfsr (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (start_ok),
    .step  (lfsr_step),
    .seed  (seed),
    .value (lfsr_val)
  );

  // Operand pair and reference result for the current test
  assign op0_sel = use_ext_q ? ext0_q : lfsr_val[DATA_WIDTH-1:0];
  assign op1_sel = use_ext_q ? ext1_q : lfsr_val[31 -: DATA_WIDTH];
  assign exp_sel = DATA_WIDTH'(compute_expected(32'(op0_sel), 32'(op1_sel), mode_q));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      mode_q        <= OP_ADD;
      use_ext_q     <= 1'b0;
      ext0_q        <= '0;
      ext1_q        <= '0;
      num_q         <= '0;
      idx           <= '0;
      tmr           <= '0;
      timed_out     <= 1'b0;
      op1_q         <= '0;
      exp_q         <= '0;
      act_q         <= '0;
      cpu_n_rst     <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      timeout_seen  <= 1'b0;
      fail_valid    <= 1'b0;
      fail_index    <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q        <= op_mode_t'(op_mode);
            use_ext_q     <= use_ext;
            ext0_q        <= ext_op0;
            ext1_q        <= ext_op1;
            num_q         <= num_tests;
            idx           <= '0;
            tmr           <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            timeout_seen  <= 1'b0;
            fail_valid    <= 1'b0;
            fail_index    <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            if (num_tests == '0) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_n_rst <= 1'b1;
            end else begin
              state     <= S_CPU_RST;
              busy      <= 1'b1;
              done      <= 1'b0;
              cpu_n_rst <= 1'b0;
            end
          end
        end

        S_CPU_RST: begin
          op1_q <= op1_sel;
          exp_q <= exp_sel;
          if (tmr == TMR_W'(RESET_CYCLES - 1)) begin
            tmr       <= '0;
            state     <= S_WR_OP0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_WIDTH'(DATA_ADDR);
            mem_wdata <= op0_sel;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_WR_OP0: begin
          if (mem_ack) begin
            state     <= S_WR_OP1;
            mem_addr  <= ADDR_WIDTH'(DATA_ADDR + 1);
            mem_wdata <= op1_q;
          end
        end

        S_WR_OP1: begin
          if (mem_ack) begin
            state     <= S_RUN;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_n_rst <= 1'b1;
            tmr       <= '0;
          end
        end

        // Halt is ignored in the first RUN cycle: it may still reflect the previous program
        S_RUN: begin
          if (cpu_halt && (tmr != '0)) begin
            state     <= S_RD_RES;
            timed_out <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_WIDTH'(DATA_ADDR + 2);
          end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_CHECK;
            timed_out <= 1'b1;
            act_q     <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_RD_RES: begin
          if (mem_ack) begin
            state   <= S_CHECK;
            act_q   <= mem_rdata;
            mem_req <= 1'b0;
          end
        end

        S_CHECK: begin
          if (!timed_out && (act_q == exp_q)) begin
            if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_WIDTH'(1);
          end else begin
            if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_WIDTH'(1);
            if (!fail_valid) begin
              fail_valid    <= 1'b1;
              fail_index    <= idx;
              fail_expected <= exp_q;
              fail_actual   <= act_q;
            end
          end
          if (timed_out) timeout_seen <= 1'b1;
          idx <= idx + CNT_WIDTH'(1);
          if ((idx + CNT_WIDTH'(1)) == num_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_CPU_RST;
            cpu_n_rst <= 1'b0;
            tmr       <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
